// File: rtl/harvos_mem_pkg.sv
// Shared types and helpers for the three-port memory arbiter.
// Requester indices are also the round-robin order D -> I -> X -> D.
package harvos_mem_pkg;

   localparam int NUM_REQ = 3;

   typedef enum logic [1:0] {
      REQ_D = 2'd0,
      REQ_I = 2'd1,
      REQ_X = 2'd2
   } req_idx_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // The instruction port has no byte enables of its own.
   localparam logic [3:0] BE_ALL = 4'hF;

   // Successor of a requester index in round-robin order (mod 3).
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         REQ_D:   nxt = REQ_I;
         REQ_I:   nxt = REQ_X;
         default: nxt = REQ_D;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way winner selection.
// With rr_en the search starts at 'pointer' and walks D -> I -> X -> D;
// otherwise a fixed priority d > i > x is used.
module rr_pick3
   import harvos_mem_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         pointer,
   input  logic               rr_en,
   output logic               any,
   output logic [1:0]         winner
);

   // Pick the first active requester in the search order selected by rr_en/pointer.
   always_comb begin
      any    = |req;
      winner = REQ_D;
      if (rr_en) begin
         case (pointer)
            REQ_I: begin
               if (req[REQ_I])      winner = REQ_I;
               else if (req[REQ_X]) winner = REQ_X;
               else if (req[REQ_D]) winner = REQ_D;
               else                 winner = REQ_D;
            end
            REQ_X: begin
               if (req[REQ_X])      winner = REQ_X;
               else if (req[REQ_D]) winner = REQ_D;
               else if (req[REQ_I]) winner = REQ_I;
               else                 winner = REQ_D;
            end
            default: begin
               if (req[REQ_D])      winner = REQ_D;
               else if (req[REQ_I]) winner = REQ_I;
               else if (req[REQ_X]) winner = REQ_X;
               else                 winner = REQ_D;
            end
         endcase
      end else begin
         if (req[REQ_D])      winner = REQ_D;
         else if (req[REQ_I]) winner = REQ_I;
         else if (req[REQ_X]) winner = REQ_X;
         else                 winner = REQ_D;
      end
   end

endmodule

// File: rtl/mem_arbiter3_rr.sv
// Three-requester memory arbiter (data, instruction-fetch, DMA/debug).
// One transaction is outstanding at a time; the grant is held until the
// memory answers or the timeout fires, so a response can only ever be
// routed to the requester that issued it. Responses arriving while IDLE
// (e.g. late answers to a timed-out access) are dropped.
module mem_arbiter3_rr
   import harvos_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int RR_EN          = 1
)
(
   input  logic        clk,
   input  logic        rst_n,
   // data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,
   output logic        d_fault,
   // instruction-fetch port (read-only)
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_rvalid,
   output logic        i_fault,
   // DMA / debug port
   input  logic        x_req,
   input  logic        x_we,
   input  logic [3:0]  x_be,
   input  logic [31:0] x_addr,
   input  logic [31:0] x_wdata,
   output logic [31:0] x_rdata,
   output logic        x_rvalid,
   output logic        x_fault,
   // memory side
   output logic        m_req,
   output logic        m_we,
   output logic [3:0]  m_be,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_rvalid,
   input  logic        m_fault,
   output logic        to_pulse
);

   // A zero TIMEOUT_CYCLES disables the timeout; keep a 1-bit counter then.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic             TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic             RR_ON    = (RR_EN != 0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1)
                                                               : {CNT_W{1'b0}};

   arb_state_e         state;
   logic [1:0]         gnt_q;
   logic [1:0]         ptr;
   logic [CNT_W-1:0]   cnt;

   logic [NUM_REQ-1:0] req_vec;
   logic               pick_any;
   logic [1:0]         pick_win;
   logic               busy;
   logic               resp;
   logic               timeout_hit;
   logic               done;
   logic               g_rvalid;
   logic               g_fault;
   logic [31:0]        g_rdata;

   assign req_vec = {x_req, i_req, d_req};

   rr_pick3 u_pick (
      .req     (req_vec),
      .pointer (ptr),
      .rr_en   (RR_ON),
      .any     (pick_any),
      .winner  (pick_win)
   );

   // Completion qualifiers: a response wins over a timeout in the same cycle,
   // and a memory fault wins over rvalid.
   always_comb begin
      busy        = (state == ARB_BUSY);
      resp        = busy & (m_rvalid | m_fault);
      timeout_hit = TO_EN & busy & ~(m_rvalid | m_fault) & (cnt == CNT_LAST);
      done        = resp | timeout_hit;
      g_fault     = busy & (m_fault | timeout_hit);
      g_rvalid    = busy & m_rvalid & ~m_fault;
      g_rdata     = 32'h0000_0000;
      if (g_rvalid) begin
         g_rdata = m_rdata;
      end else begin
         g_rdata = 32'h0000_0000;
      end
   end

   // Arbitration FSM, grant latch, round-robin pointer and timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
         gnt_q <= REQ_D;
         ptr   <= REQ_D;
         cnt   <= {CNT_W{1'b0}};
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  state <= ARB_BUSY;
                  gnt_q <= pick_win;
                  cnt   <= {CNT_W{1'b0}};
               end
            end
            ARB_BUSY: begin
               if (done) begin
                  state <= ARB_IDLE;
                  if (RR_ON) begin
                     ptr <= next_idx(gnt_q);
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   // Memory-side request: the granted port's live attributes while BUSY, else all zero.
   always_comb begin
      m_req   = 1'b0;
      m_we    = 1'b0;
      m_be    = 4'h0;
      m_addr  = 32'h0000_0000;
      m_wdata = 32'h0000_0000;
      if (busy) begin
         m_req = 1'b1;
         case (gnt_q)
            REQ_D: begin
               m_we    = d_we;
               m_be    = d_be;
               m_addr  = d_addr;
               m_wdata = d_wdata;
            end
            REQ_I: begin
               m_we    = 1'b0;
               m_be    = BE_ALL;
               m_addr  = i_addr;
               m_wdata = 32'h0000_0000;
            end
            REQ_X: begin
               m_we    = x_we;
               m_be    = x_be;
               m_addr  = x_addr;
               m_wdata = x_wdata;
            end
            default: begin
               m_we    = 1'b0;
               m_be    = 4'h0;
               m_addr  = 32'h0000_0000;
               m_wdata = 32'h0000_0000;
            end
         endcase
      end else begin
         m_req = 1'b0;
      end
   end

   // Route the completion to the granted port only; all other ports stay quiet.
   always_comb begin
      d_rvalid = 1'b0;
      d_fault  = 1'b0;
      d_rdata  = 32'h0000_0000;
      i_rvalid = 1'b0;
      i_fault  = 1'b0;
      i_rdata  = 32'h0000_0000;
      x_rvalid = 1'b0;
      x_fault  = 1'b0;
      x_rdata  = 32'h0000_0000;
      to_pulse = timeout_hit;
      case (gnt_q)
         REQ_D: begin
            d_rvalid = g_rvalid;
            d_fault  = g_fault;
            d_rdata  = g_rdata;
         end
         REQ_I: begin
            i_rvalid = g_rvalid;
            i_fault  = g_fault;
            i_rdata  = g_rdata;
         end
         REQ_X: begin
            x_rvalid = g_rvalid;
            x_fault  = g_fault;
            x_rdata  = g_rdata;
         end
         default: begin
            d_rvalid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter3_rr.sv
// Self-checking bench for mem_arbiter3_rr.
// dut_a: round-robin, TIMEOUT_CYCLES = 4 (scoreboarded completions).
// dut_b: fixed priority, TIMEOUT_CYCLES = 4 (direct checks).
// Inputs are driven 1 time unit after posedge; outputs sampled at negedge.
module tb_mem_arbiter3_rr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        d_req, i_req, x_req, d_we, x_we;
   logic [3:0]  d_be, x_be;
   logic [31:0] d_addr, i_addr, x_addr, d_wdata, x_wdata;
   logic [31:0] m_rdata;
   logic        m_rvalid, m_fault;

   logic [31:0] d_rdata, i_rdata, x_rdata, m_addr, m_wdata;
   logic        d_rvalid, i_rvalid, x_rvalid, d_fault, i_fault, x_fault;
   logic        m_req, m_we, to_pulse;
   logic [3:0]  m_be;

   logic [31:0] b_d_rdata, b_i_rdata, b_x_rdata, b_m_addr, b_m_wdata;
   logic        b_d_rvalid, b_i_rvalid, b_x_rvalid, b_d_fault, b_i_fault, b_x_fault;
   logic        b_m_req, b_m_we, b_to_pulse;
   logic [3:0]  b_m_be;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        mon_en   = 1'b1;
   logic [127:0] exp_q[$];

   always #5 clk = ~clk;

   mem_arbiter3_rr #(.TIMEOUT_CYCLES(4), .RR_EN(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_fault(d_fault),
      .i_req(i_req), .i_addr(i_addr),
      .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_fault(i_fault),
      .x_req(x_req), .x_we(x_we), .x_be(x_be), .x_addr(x_addr), .x_wdata(x_wdata),
      .x_rdata(x_rdata), .x_rvalid(x_rvalid), .x_fault(x_fault),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_fault(m_fault), .to_pulse(to_pulse)
   );

   mem_arbiter3_rr #(.TIMEOUT_CYCLES(4), .RR_EN(0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(b_d_rdata), .d_rvalid(b_d_rvalid), .d_fault(b_d_fault),
      .i_req(i_req), .i_addr(i_addr),
      .i_rdata(b_i_rdata), .i_rvalid(b_i_rvalid), .i_fault(b_i_fault),
      .x_req(x_req), .x_we(x_we), .x_be(x_be), .x_addr(x_addr), .x_wdata(x_wdata),
      .x_rdata(b_x_rdata), .x_rvalid(b_x_rvalid), .x_fault(b_x_fault),
      .m_req(b_m_req), .m_we(b_m_we), .m_be(b_m_be), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_fault(m_fault), .to_pulse(b_to_pulse)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Response view: {pad, d_rv, d_f, i_rv, i_f, x_rv, x_f, to, d_rdata, i_rdata, x_rdata}
   function automatic logic [127:0] resp_a();
      return {25'd0, d_rvalid, d_fault, i_rvalid, i_fault, x_rvalid, x_fault, to_pulse,
              d_rdata, i_rdata, x_rdata};
   endfunction

   function automatic logic [127:0] resp_b();
      return {25'd0, b_d_rvalid, b_d_fault, b_i_rvalid, b_i_fault, b_x_rvalid, b_x_fault,
              b_to_pulse, b_d_rdata, b_i_rdata, b_x_rdata};
   endfunction

   function automatic logic [127:0] bus_a();
      return {58'd0, m_req, m_we, m_be, m_addr, m_wdata};
   endfunction

   function automatic logic [127:0] bus_b();
      return {58'd0, b_m_req, b_m_we, b_m_be, b_m_addr, b_m_wdata};
   endfunction

   // Expected memory bus when 'port' holds the grant (0=D, 1=I, 2=X).
   function automatic logic [127:0] exp_bus(input int port);
      logic [127:0] v;
      case (port)
         0:       v = {58'd0, 1'b1, d_we, d_be, d_addr, d_wdata};
         1:       v = {58'd0, 1'b1, 1'b0, 4'hF, i_addr, 32'h0000_0000};
         default: v = {58'd0, 1'b1, x_we, x_be, x_addr, x_wdata};
      endcase
      return v;
   endfunction

   // Expected response view for a completion on 'port'.
   function automatic logic [127:0] mk(input int port, input logic rv, input logic flt,
                                       input logic to, input logic [31:0] rd);
      logic [127:0] v;
      case (port)
         0:       v = {25'd0, rv, flt, 4'b0000, to, rd, 64'd0};
         1:       v = {25'd0, 2'b00, rv, flt, 2'b00, to, 32'd0, rd, 32'd0};
         default: v = {25'd0, 4'b0000, rv, flt, to, 64'd0, rd};
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      d_req    = 1'b0;
      i_req    = 1'b0;
      x_req    = 1'b0;
      m_rvalid = 1'b0;
      m_fault  = 1'b0;
      m_rdata  = 32'h0000_0000;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: every completion pulse on dut_a pops one expectation.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (resp_a() != 128'd0) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_resp", resp_a(), 128'd0);
            end else begin
               check_eq("sb_resp", resp_a(), exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      d_req = 1'b0; i_req = 1'b0; x_req = 1'b0;
      d_we = 1'b0; x_we = 1'b0; d_be = 4'h0; x_be = 4'h0;
      d_addr = 32'h0; i_addr = 32'h0; x_addr = 32'h0;
      d_wdata = 32'h0; x_wdata = 32'h0;
      m_rdata = 32'h0; m_rvalid = 1'b0; m_fault = 1'b0;

      // Reset state: everything quiet.
      tick();
      @(negedge clk);
      check_eq("rst_bus_a", bus_a(), 128'd0);
      check_eq("rst_resp_a", resp_a(), 128'd0);
      check_eq("rst_bus_b", bus_b(), 128'd0);
      check_eq("rst_resp_b", resp_b(), 128'd0);
      do_reset();

      // Single read on D.
      tick();
      d_req = 1'b1; d_addr = 32'h0000_0100; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
      @(negedge clk);
      check_eq("single_c0_idle", bus_a(), 128'd0);
      tick();
      @(negedge clk);
      check_eq("single_c1_bus", bus_a(), exp_bus(0));
      tick();
      tick();
      m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
      exp_q.push_back(mk(0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF));
      @(negedge clk);
      tick();
      m_rvalid = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check_eq("single_c4_idle", bus_a(), 128'd0);

      // Round-robin with all three held: D, I, X, D.
      do_reset();
      d_addr = 32'h10; d_we = 1'b0; d_be = 4'h3; d_wdata = 32'hD0D0_D0D0;
      i_addr = 32'h20;
      x_addr = 32'h30; x_we = 1'b1; x_be = 4'hC; x_wdata = 32'hA5A5_5A5A;
      for (int k = 0; k < 4; k++) begin
         tick();
         d_req = 1'b1; i_req = 1'b1; x_req = 1'b1;
         m_rvalid = 1'b0;
         @(negedge clk);
         check_eq("rr_idle", bus_a(), 128'd0);
         tick();
         m_rvalid = 1'b1; m_rdata = 32'hC000_0000 + 32'(k);
         exp_q.push_back(mk(k % 3, 1'b1, 1'b0, 1'b0, 32'hC000_0000 + 32'(k)));
         @(negedge clk);
         check_eq("rr_grant", bus_a(), exp_bus(k % 3));
      end
      tick();
      d_req = 1'b0; i_req = 1'b0; x_req = 1'b0; m_rvalid = 1'b0;
      tick();
      @(negedge clk);
      check_eq("rr_done_idle", bus_a(), 128'd0);

      // Fixed priority on dut_b: D wins while held, then I.
      mon_en = 1'b0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         tick();
         d_req = 1'b1; i_req = 1'b1; m_rvalid = 1'b0;
         @(negedge clk);
         check_eq("fp_idle", bus_b(), 128'd0);
         tick();
         m_rvalid = 1'b1; m_rdata = 32'hB000_0000 + 32'(k);
         @(negedge clk);
         check_eq("fp_grant_d", bus_b(), exp_bus(0));
         check_eq("fp_resp_d", resp_b(), mk(0, 1'b1, 1'b0, 1'b0, 32'hB000_0000 + 32'(k)));
      end
      tick();
      d_req = 1'b0; m_rvalid = 1'b0;
      tick();
      m_rvalid = 1'b1; m_rdata = 32'hB111_1111;
      @(negedge clk);
      check_eq("fp_grant_i", bus_b(), exp_bus(1));
      check_eq("fp_resp_i", resp_b(), mk(1, 1'b1, 1'b0, 1'b0, 32'hB111_1111));
      tick();
      i_req = 1'b0; m_rvalid = 1'b0;
      do_reset();
      mon_en = 1'b1;

      // Timeout on I after 4 BUSY cycles; late response ignored.
      tick();
      i_req = 1'b1; i_addr = 32'h40;
      for (int k = 1; k <= 3; k++) begin
         tick();
         @(negedge clk);
         check_eq("to_wait_bus", bus_a(), exp_bus(1));
         check_eq("to_wait_resp", resp_a(), 128'd0);
      end
      tick();
      exp_q.push_back(mk(1, 1'b0, 1'b1, 1'b1, 32'h0));
      @(negedge clk);
      tick();
      i_req = 1'b0;
      @(negedge clk);
      check_eq("to_c5_idle", bus_a(), 128'd0);
      tick();
      m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check_eq("to_late_rsp", resp_a(), 128'd0);
      tick();
      m_rvalid = 1'b0;

      // Response in the final BUSY cycle wins over the timeout.
      tick();
      i_req = 1'b1; i_addr = 32'h44;
      tick();
      tick();
      tick();
      tick();
      m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
      exp_q.push_back(mk(1, 1'b1, 1'b0, 1'b0, 32'h1234_5678));
      @(negedge clk);
      tick();
      m_rvalid = 1'b0; i_req = 1'b0;
      @(negedge clk);
      check_eq("last_cycle_idle", bus_a(), 128'd0);

      // Fault precedence on X.
      tick();
      x_req = 1'b1; x_addr = 32'h30;
      tick();
      m_rvalid = 1'b1; m_fault = 1'b1; m_rdata = 32'hFFFF_FFFF;
      exp_q.push_back(mk(2, 1'b0, 1'b1, 1'b0, 32'h0));
      @(negedge clk);
      check_eq("fp_x_bus", bus_a(), exp_bus(2));
      tick();
      m_rvalid = 1'b0; m_fault = 1'b0; x_req = 1'b0;

      // Asynchronous reset while D is granted; pending X granted afterwards.
      tick();
      tick();
      d_req = 1'b1; d_addr = 32'h80;
      tick();
      x_req = 1'b1; x_addr = 32'h90;
      @(negedge clk);
      check_eq("rst_mid_busy", bus_a(), exp_bus(0));
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_bus", bus_a(), 128'd0);
      check_eq("rst_async_resp", resp_a(), 128'd0);
      tick();
      d_req = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_rel_idle", bus_a(), 128'd0);
      tick();
      m_rvalid = 1'b1; m_rdata = 32'h0000_0077;
      exp_q.push_back(mk(2, 1'b1, 1'b0, 1'b0, 32'h0000_0077));
      @(negedge clk);
      check_eq("rst_rel_grant_x", bus_a(), exp_bus(2));
      tick();
      m_rvalid = 1'b0; x_req = 1'b0;
      tick();
      @(negedge clk);
      check_eq("final_idle", bus_a(), 128'd0);
      check_eq("sb_empty", 128'(exp_q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
